// File: rtl/vpu_issue_sched_pkg.sv
// Shared types for the VPU issue scheduler: FSM states, default credit depth,
// the host-to-decoder instruction format and its source-operand accessor.
package vpu_issue_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int unsigned VPU_MAX_OUTSTANDING = 4;
  localparam int unsigned SRAM_R_PORT_CNT     = 3;

  typedef logic [7:0] vpu_reg_t;

  typedef struct packed {
    logic [7:0] opcode;
    vpu_reg_t   dst0;
    vpu_reg_t   src0;
    vpu_reg_t   src1;
    vpu_reg_t   src2;
  } vpu_h2d_req_instr_t;

  function automatic vpu_reg_t get_src_operand(input vpu_h2d_req_instr_t instr,
                                               input int unsigned k);
    case (k)
      0:       return instr.src0;
      1:       return instr.src1;
      default: return instr.src2;
    endcase
  endfunction

endpackage

// File: rtl/vpu_issue_sched_arb.sv
// Combinational round-robin arbiter: grants the first eligible index after
// the supplied pointer, searching cyclically.
module vpu_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_eligible,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((32'(i_ptr) + off) % NUM_REQ);
      if (!o_any && i_eligible[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/vpu_issue_sched.sv
// Round-robin issue scheduler feeding the shared VPU decoder with credit-limited
// in-flight tracking and flush/drain. Optional RAW hazard table: VPU_SCHED_RAW_CHK_EN.
module vpu_issue_sched
  import vpu_issue_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned MAX_OUTSTANDING = VPU_MAX_OUTSTANDING,
  parameter int unsigned INSTR_W         = $bits(vpu_h2d_req_instr_t)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*INSTR_W-1:0]         req_instr_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic                               dec_valid_o,
  output logic [INSTR_W-1:0]                 dec_instr_o,
  output logic [$clog2(NUM_REQ)-1:0]         dec_src_id_o,
  input  logic                               dec_ready_i,
  input  logic                               wb_done_i,
  input  logic                               flush_i,
  output logic                               busy_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                               err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  sched_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic [INSTR_W-1:0] r_instr;
  logic [IDX_W-1:0]   r_src;

  vpu_h2d_req_instr_t w_req_instr [NUM_REQ];
  logic [NUM_REQ-1:0] w_hazard;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gidx;
  logic               w_gany;
  logic               w_hs;
  logic               w_credit_ok;
  logic               w_capture;
  logic               w_wb_ok;
  logic               w_wb_err;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_req_instr[i] = req_instr_i[i*INSTR_W +: INSTR_W];
    end
  end

  assign w_hs     = (r_state == ISSUE) && dec_ready_i;
  assign w_wb_ok  = wb_done_i && (r_cnt != '0);
  assign w_wb_err = wb_done_i && (r_cnt == '0);

  // The held instruction occupies a credit whether it handshakes this cycle
  // or not, so a back-to-back capture can never push the count past the limit.
  assign w_credit_ok = (32'(r_cnt) + 32'(r_state == ISSUE)) < MAX_OUTSTANDING;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req_valid_i[i] && !flush_i && w_credit_ok && !w_hazard[i];
    end
  end

  vpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_gidx),
    .o_any      (w_gany)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush_i) begin
          w_state_nxt = DRAIN;
        end else if (w_gany) begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_hs) begin
          if (w_gany) begin
            w_capture   = 1'b1;
            w_state_nxt = ISSUE;
          end else if (flush_i) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DRAIN: begin
        if ((r_cnt == '0) && !flush_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign req_ready_o = w_capture ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_instr <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_instr <= w_req_instr[w_gidx];
        r_src   <= w_gidx;
        r_ptr   <= w_gidx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case ({w_hs, w_wb_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_wb_err) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef VPU_SCHED_RAW_CHK_EN
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  vpu_reg_t                   r_raw_dst [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] r_raw_vld;
  logic [PTR_W-1:0]           r_raw_wr;
  logic [PTR_W-1:0]           r_raw_rd;
  vpu_h2d_req_instr_t         w_held;
  vpu_reg_t                   w_src;

  assign w_held = r_instr;

  // All source slots are checked regardless of opcode; false blocks are cheap.
  always_comb begin
    w_hazard = '0;
    w_src    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned k = 0; k < SRAM_R_PORT_CNT; k++) begin
        w_src = get_src_operand(w_req_instr[i], k);
        if ((r_state == ISSUE) && (w_src == w_held.dst0)) begin
          w_hazard[i] = 1'b1;
        end
        for (int unsigned e = 0; e < MAX_OUTSTANDING; e++) begin
          if (r_raw_vld[e] && (w_src == r_raw_dst[e])) begin
            w_hazard[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned e = 0; e < MAX_OUTSTANDING; e++) begin
        r_raw_dst[e] <= '0;
      end
      r_raw_vld <= '0;
      r_raw_wr  <= '0;
      r_raw_rd  <= '0;
    end else begin
      if (w_hs) begin
        r_raw_dst[r_raw_wr] <= w_held.dst0;
        r_raw_vld[r_raw_wr] <= 1'b1;
        r_raw_wr <= (r_raw_wr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_raw_wr + PTR_W'(1);
      end
      if (w_wb_ok) begin
        r_raw_vld[r_raw_rd] <= 1'b0;
        r_raw_rd <= (r_raw_rd == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_raw_rd + PTR_W'(1);
      end
    end
  end
`else
  assign w_hazard = '0;
`endif

  assign dec_valid_o   = (r_state == ISSUE);
  assign dec_instr_o   = r_instr;
  assign dec_src_id_o  = r_src;
  assign outstanding_o = r_cnt;
  assign err_o         = r_err;
  assign busy_o        = (r_state != IDLE) || (r_cnt != '0);

endmodule

// File: tb/tb_vpu_issue_sched.sv
// Self-checking bench for vpu_issue_sched: directed scenarios plus random traffic
// against a transaction-level reference model (RAW checks follow VPU_SCHED_RAW_CHK_EN).
module tb_vpu_issue_sched;
  import vpu_issue_sched_pkg::*;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXA = 4;
  localparam int unsigned MAXB = 2;
  localparam int unsigned W    = $bits(vpu_h2d_req_instr_t);

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_instr = '0;
  logic             dec_ready = 1'b0;
  logic             wb_done = 1'b0;
  logic             flush = 1'b0;

  logic [N-1:0]     a_ready, b_ready;
  logic             a_valid, b_valid;
  logic [W-1:0]     a_instr, b_instr;
  logic [1:0]       a_src, b_src;
  logic             a_busy, b_busy;
  logic [2:0]       a_out;
  logic [1:0]       b_out;
  logic             a_err, b_err;

  always #5 clk = ~clk;

  vpu_issue_sched #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_instr_i(req_instr),
    .req_ready_o(a_ready), .dec_valid_o(a_valid), .dec_instr_o(a_instr),
    .dec_src_id_o(a_src), .dec_ready_i(dec_ready), .wb_done_i(wb_done),
    .flush_i(flush), .busy_o(a_busy), .outstanding_o(a_out), .err_o(a_err));

  vpu_issue_sched #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_instr_i(req_instr),
    .req_ready_o(b_ready), .dec_valid_o(b_valid), .dec_instr_o(b_instr),
    .dec_src_id_o(b_src), .dec_ready_i(dec_ready), .wb_done_i(wb_done),
    .flush_i(flush), .busy_o(b_busy), .outstanding_o(b_out), .err_o(b_err));

  int checks = 0;
  int failures = 0;

  // reference model state (instance A)
  bit                 m_held_v;
  vpu_h2d_req_instr_t m_held;
  int                 m_held_src;
  int                 m_cnt;
  vpu_reg_t           m_fly[$];
  int                 m_last;
  bit                 m_drain;
  bit                 m_err;
  int                 cap_log[$];
  logic [1:0]         hs_hist;

  bit                 e_hs, e_cap;
  int                 e_g;
  logic [N-1:0]       e_ready;

  logic [N-1:0] a_ready_s, b_ready_s;
  logic         a_valid_s, b_valid_s, a_busy_s, a_err_s, b_hs_s;
  logic [W-1:0] a_instr_s;
  logic [1:0]   a_src_s;
  logic [2:0]   a_out_s;
  logic [1:0]   b_out_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vpu_h2d_req_instr_t slot(input int i);
    return req_instr[i*W +: W];
  endfunction

  task automatic set_slot(input int i, input vpu_h2d_req_instr_t x);
    req_instr[i*W +: W] = x;
  endtask

  function automatic vpu_h2d_req_instr_t mk(input logic [7:0] op, input logic [7:0] d,
                                            input logic [7:0] s0, input logic [7:0] s1,
                                            input logic [7:0] s2);
    vpu_h2d_req_instr_t x;
    x.opcode = op; x.dst0 = d; x.src0 = s0; x.src1 = s1; x.src2 = s2;
    return x;
  endfunction

  function automatic bit hazard(input vpu_h2d_req_instr_t x);
    bit h = 0;
`ifdef VPU_SCHED_RAW_CHK_EN
    vpu_reg_t s[3];
    s[0] = x.src0; s[1] = x.src1; s[2] = x.src2;
    foreach (s[k]) begin
      if (m_held_v && s[k] == m_held.dst0) h = 1;
      foreach (m_fly[j]) if (s[k] == m_fly[j]) h = 1;
    end
`endif
    return h;
  endfunction

  task automatic model_reset();
    m_held_v = 0; m_held = '0; m_held_src = 0; m_cnt = 0; m_fly.delete();
    m_last = N - 1; m_drain = 0; m_err = 0; cap_log.delete(); hs_hist = '0;
  endtask

  task automatic step();
    bit can, held_before;
    int cnt0, idx;
    @(negedge clk);
    e_hs  = m_held_v && dec_ready;
    can   = !m_drain && (!m_held_v || e_hs) && !flush && (m_cnt + int'(m_held_v) < int'(MAXA));
    e_cap = 0; e_g = 0; e_ready = '0;
    for (int off = 1; off <= int'(N); off++) begin
      idx = (m_last + off) % N;
      if (!e_cap && can && req_valid[idx] && !hazard(slot(idx))) begin
        e_cap = 1; e_g = idx;
      end
    end
    if (e_cap) e_ready[e_g] = 1'b1;
    a_ready_s = a_ready; a_valid_s = a_valid; a_instr_s = a_instr; a_src_s = a_src;
    a_out_s = a_out; a_busy_s = a_busy; a_err_s = a_err;
    b_ready_s = b_ready; b_valid_s = b_valid; b_out_s = b_out; b_hs_s = b_valid && dec_ready;
    chk("req_ready", a_ready, e_ready);
    chk("dec_valid", a_valid, m_held_v);
    if (m_held_v) begin
      chk("dec_instr", a_instr, m_held);
      chk("dec_src_id", a_src, m_held_src);
    end
    chk("outstanding", a_out, m_cnt);
    chk("err", a_err, m_err);
    chk("busy", a_busy, m_held_v || m_drain || (m_cnt != 0));
    @(posedge clk);
    cnt0 = m_cnt;
    held_before = m_held_v;
    if (e_hs) begin
      m_fly.push_back(m_held.dst0);
      m_cnt++;
      m_held_v = 0;
    end
    if (wb_done) begin
      if (cnt0 > 0) begin
        m_cnt--;
        void'(m_fly.pop_front());
      end else begin
        m_err = 1;
      end
    end
    if (m_drain) m_drain = !(cnt0 == 0 && !flush);
    else if (flush && (!held_before || (e_hs && !e_cap))) m_drain = 1;
    if (e_cap) begin
      m_held = slot(e_g); m_held_src = e_g; m_held_v = 1; m_last = e_g;
      cap_log.push_back(e_g);
    end
    hs_hist = {hs_hist[0], e_hs};
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; dec_ready = 1'b0; wb_done = 1'b0; flush = 1'b0;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_instr", a_instr, 0);
    chk("rst_a_src", a_src, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_b_valid", b_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic clean_slots();
    for (int i = 0; i < int'(N); i++)
      set_slot(i, mk(8'(i + 1), 8'(8'h80 + i), 8'h40, 8'h41, 8'h42));
  endtask

  initial begin
    int exp_order[5];
    int exp_b[10];
    int bhs;
    vpu_h2d_req_instr_t held_ref;
    int got;

    #1;
    model_reset();
    do_reset();

    // all four requesters valid, decoder always ready, completions echoed at +2
    clean_slots();
    req_valid = 4'hF; dec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      wb_done = hs_hist[1];
      step();
      if (c >= 1) chk("p1_dec_valid_cont", a_valid_s, 1);
    end
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      got = (k < cap_log.size()) ? cap_log[k] : -1;
      chk($sformatf("p1_order%0d", k), got, exp_order[k]);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      wb_done = hs_hist[1];
      step();
    end
    wb_done = 1'b0;

    // credit limit on the MAX_OUTSTANDING=2 instance
    do_reset();
    clean_slots();
    req_valid = 4'hF; dec_ready = 1'b1;
    exp_b = '{1, 2, 0, 0, 0, 0, 0, 4, 0, 8};
    bhs = 0;
    for (int c = 0; c < 10; c++) begin
      wb_done = (c == 6 || c == 8);
      step();
      chk($sformatf("p2_b_ready%0d", c), b_ready_s, exp_b[c]);
      if (c < 6) bhs += int'(b_hs_s);
      if (c >= 3 && c <= 6) chk($sformatf("p2_b_out%0d", c), b_out_s, 2);
      if (c == 7 || c == 9) chk($sformatf("p2_b_out%0d", c), b_out_s, 1);
    end
    chk("p2_b_handshakes", bhs, 2);
    wb_done = 1'b0;

    // decoder stall: held instruction stable, other requesters get no ready
    do_reset();
    clean_slots();
    set_slot(0, mk(8'h5A, 8'h91, 8'h33, 8'h34, 8'h35));
    held_ref = slot(0);
    req_valid = 4'b0001; dec_ready = 1'b0;
    step();
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("p3_stall_ready", a_ready_s, 0);
      chk("p3_stall_instr", a_instr_s, held_ref);
      chk("p3_stall_src", a_src_s, 0);
    end
    req_valid = '0; dec_ready = 1'b1;
    step();
    wb_done = 1'b1; step();
    wb_done = 1'b0; step();

    // flush with three operations outstanding
    do_reset();
    clean_slots();
    req_valid = 4'b0111; dec_ready = 1'b1;
    repeat (3) step();
    req_valid = '0;
    step();
    flush = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      wb_done = (c == 2 || c == 4 || c == 6);
      step();
      chk("p4_flush_ready", a_ready_s, 0);
    end
    wb_done = 1'b0; flush = 1'b0; req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (!a_busy_s) break;
    end
    chk("p4_idle_busy", a_busy_s, 0);
    chk("p4_idle_out", a_out_s, 0);

    // completion with nothing outstanding
    do_reset();
    wb_done = 1'b1; step();
    wb_done = 1'b0; step();
    chk("p5_err", a_err_s, 1);
    chk("p5_out", a_out_s, 0);

`ifdef VPU_SCHED_RAW_CHK_EN
    do_reset();
    set_slot(0, mk(8'h01, 8'h10, 8'h01, 8'h02, 8'h03));
    set_slot(1, mk(8'h02, 8'h20, 8'h05, 8'h10, 8'h06));
    set_slot(2, mk(8'h03, 8'h30, 8'h04, 8'h07, 8'h08));
    set_slot(3, mk(8'h04, 8'h40, 8'h09, 8'h0A, 8'h0B));
    dec_ready = 1'b1;
    req_valid = 4'b0001; step();
    req_valid = 4'b0110; step();
    chk("raw_req2_wins", a_ready_s, 4'b0100);
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("raw_req1_blocked", a_ready_s, 0);
    end
    wb_done = 1'b1; step();
    chk("raw_block_until_wb", a_ready_s, 0);
    wb_done = 1'b0; step();
    chk("raw_req1_granted", a_ready_s, 4'b0010);
    exp_order = '{0, 2, 1, 0, 0};
    for (int k = 0; k < 3; k++) begin
      got = (k < cap_log.size()) ? cap_log[k] : -1;
      chk($sformatf("raw_order%0d", k), got, exp_order[k]);
    end
`endif

    // random traffic with a reset in the middle of operation
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      req_valid = N'($urandom);
      for (int i = 0; i < int'(N); i++)
        set_slot(i, mk(8'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                       8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))));
      dec_ready = ($urandom % 4) != 0;
      wb_done   = (m_cnt > 0) && (($urandom % 3) == 0);
      if (($urandom % 40) == 0) flush = !flush;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
